counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_wrap_counter.sv | 27 ++
 rtl/counter.sv | 49 ++++
 tb/tb_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared widths and parameter-range helper for the raster counter.
package counter_pkg;

  localparam int COORD_W = 16;
  localparam int MAX_DIM = 65536;

  function automatic bit dim_ok(input int n);
    return (n >= 1) && (n <= MAX_DIM);
  endfunction

endpackage

// File: rtl/counter_wrap_counter.sv
// Modulo-MAX counter: advances on inc, returns to 0 after MAX-1, flags the wrapping step.
module wrap_counter #(
  parameter int MAX   = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic             wrap,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  // wrap is a decode of the register and inc, so it is valid in the same cycle as q.
  assign wrap = inc && (q == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (inc) begin
      if (q == LAST) q <= '0;
      else           q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter.sv
// Raster position counter: column x, row y, and a count of completed frames.
module counter
  import counter_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int ROW_NUMBER = 480
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_end,
  output logic               frame_end,
  output logic [COORD_W-1:0] frame_count
);

  if (!dim_ok(LINE_WIDTH) || !dim_ok(ROW_NUMBER)) begin : g_bad_param
    $error("counter: LINE_WIDTH and ROW_NUMBER must be in 1..65536");
  end

  logic x_wrap;
  logic y_wrap;

  wrap_counter #(.MAX(LINE_WIDTH), .WIDTH(COORD_W)) u_x (
    .clk  (clk),
    .rst  (rst),
    .inc  (1'b1),
    .wrap (x_wrap),
    .q    (x)
  );

  // The row advances only on the column's wrapping step, so its wrap is the frame end.
  wrap_counter #(.MAX(ROW_NUMBER), .WIDTH(COORD_W)) u_y (
    .clk  (clk),
    .rst  (rst),
    .inc  (x_wrap),
    .wrap (y_wrap),
    .q    (y)
  );

  assign line_end  = x_wrap;
  assign frame_end = y_wrap;

  always_ff @(posedge clk) begin
    if (!rst)           frame_count <= '0;
    else if (frame_end) frame_count <= frame_count + COORD_W'(1);
  end

endmodule

// File: tb/tb_counter.sv
// Bench for counter: constant vector table, corner sequences, and a randomized run against a count-based model.
module tb_counter;

  logic clk;
  logic rst_a, rst_b, rst_c;

  logic [15:0] x_a, y_a, fc_a;
  logic        le_a, fe_a;
  logic [15:0] x_b, y_b, fc_b;
  logic        le_b, fe_b;
  logic [15:0] x_c, y_c, fc_c;
  logic        le_c, fe_c;
  logic [15:0] x_d, y_d, fc_d;
  logic        le_d, fe_d;

  int n_checks = 0;
  int n_fail   = 0;

  // edges with reset high since the last reset edge, per instance
  longint n_a = 0, n_b = 0, n_c = 0, n_d = 0;

  counter #(.LINE_WIDTH(10), .ROW_NUMBER(3)) dut_a (
    .clk(clk), .rst(rst_a), .x(x_a), .y(y_a),
    .line_end(le_a), .frame_end(fe_a), .frame_count(fc_a)
  );
  counter #(.LINE_WIDTH(1), .ROW_NUMBER(3)) dut_b (
    .clk(clk), .rst(rst_b), .x(x_b), .y(y_b),
    .line_end(le_b), .frame_end(fe_b), .frame_count(fc_b)
  );
  counter #(.LINE_WIDTH(1), .ROW_NUMBER(1)) dut_c (
    .clk(clk), .rst(rst_c), .x(x_c), .y(y_c),
    .line_end(le_c), .frame_end(fe_c), .frame_count(fc_c)
  );
  counter #(.LINE_WIDTH(4), .ROW_NUMBER(1)) dut_d (
    .clk(clk), .rst(rst_b), .x(x_d), .y(y_d),
    .line_end(le_d), .frame_end(fe_d), .frame_count(fc_d)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic   rst;
    int     cycles;
    longint ex, ey, efc;
    logic   ele, efe;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock edge, then update the model from the reset level seen at that edge.
  task automatic step();
    @(posedge clk);
    n_a = rst_a ? n_a + 1 : 0;
    n_b = rst_b ? n_b + 1 : 0;
    n_c = rst_c ? n_c + 1 : 0;
    n_d = rst_b ? n_d + 1 : 0;
    #1;
  endtask

  // Position after n counting edges in a lw x rn raster, by plain arithmetic.
  task automatic model_check(input string name, input int lw, input int rn, input longint n,
                             input logic [15:0] x, input logic [15:0] y, input logic [15:0] fc,
                             input logic le, input logic fe);
    longint ex, ey, efc;
    ex  = n % lw;
    ey  = (n / lw) % rn;
    efc = (n / (longint'(lw) * rn)) % 65536;
    chk({name, ".x"}, x, ex);
    chk({name, ".y"}, y, ey);
    chk({name, ".frame_count"}, fc, efc);
    chk({name, ".line_end"}, le, (ex == lw - 1) ? 1 : 0);
    chk({name, ".frame_end"}, fe, (ex == lw - 1 && ey == rn - 1) ? 1 : 0);
  endtask

  initial begin
    int fe_seen;
    longint fe_x, fe_y;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    vecs[0] = '{1'b0,  1, 0, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b1,  1, 1, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1,  8, 9, 0, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b1,  1, 0, 1, 0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 19, 9, 2, 0, 1'b1, 1'b1};
    vecs[5] = '{1'b1,  1, 0, 0, 1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 15, 5, 1, 1, 1'b0, 1'b0};
    vecs[7] = '{1'b0,  1, 0, 0, 0, 1'b0, 1'b0};
    vecs[8] = '{1'b1,  1, 1, 0, 0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 32, 3, 0, 1, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst_a = vecs[i].rst;
      repeat (vecs[i].cycles) step();
      chk($sformatf("vec%0d.x", i), x_a, vecs[i].ex);
      chk($sformatf("vec%0d.y", i), y_a, vecs[i].ey);
      chk($sformatf("vec%0d.frame_count", i), fc_a, vecs[i].efc);
      chk($sformatf("vec%0d.line_end", i), le_a, vecs[i].ele);
      chk($sformatf("vec%0d.frame_end", i), fe_a, vecs[i].efe);
    end

    // One full frame after a fresh reset: frame_end exactly once, at (9,2).
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    fe_seen = 0; fe_x = -1; fe_y = -1;
    for (int i = 0; i < 30; i++) begin
      if (fe_a) begin
        fe_seen++;
        fe_x = x_a;
        fe_y = y_a;
      end
      step();
    end
    chk("frame.fe_count", fe_seen, 1);
    chk("frame.fe_x", fe_x, 9);
    chk("frame.fe_y", fe_y, 2);
    chk("frame.x", x_a, 0);
    chk("frame.y", y_a, 0);
    chk("frame.frame_count", fc_a, 1);

    // Single-pixel lines (1x3) and single-row frames (4x1).
    rst_b = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("w1.x", x_b, 0);
      chk("w1.line_end", le_b, 1);
      chk("w1.y", y_b, i % 3);
      chk("w1.frame_end", fe_b, (i % 3 == 2) ? 1 : 0);
      chk("r1.y", y_d, 0);
      chk("r1.fe_eq_le", fe_d, le_d);
    end

    // Randomized resets against the model; bounds on dut_a checked every edge.
    for (int i = 0; i < 300; i++) begin
      rst_a = ($urandom_range(0, 7) != 0);
      rst_b = ($urandom_range(0, 9) != 0);
      step();
      model_check("rnd_a", 10, 3, n_a, x_a, y_a, fc_a, le_a, fe_a);
      model_check("rnd_b", 1, 3, n_b, x_b, y_b, fc_b, le_b, fe_b);
      model_check("rnd_d", 4, 1, n_d, x_d, y_d, fc_d, le_d, fe_d);
      chk("bound.x", (x_a < 10) ? 1 : 0, 1);
      chk("bound.y", (y_a < 3) ? 1 : 0, 1);
    end

    // 1x1 raster: every edge ends a frame, so 65536 edges wrap frame_count.
    chk("wrap.reset_fc", fc_c, 0);
    rst_c = 1'b1;
    repeat (65535) step();
    chk("wrap.fc_ffff", fc_c, 65535);
    chk("wrap.frame_end", fe_c, 1);
    model_check("wrap_c", 1, 1, n_c, x_c, y_c, fc_c, le_c, fe_c);
    step();
    chk("wrap.fc_zero", fc_c, 0);
    model_check("wrap_c", 1, 1, n_c, x_c, y_c, fc_c, le_c, fe_c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
